fetch_unit: RTL and testbench

Instruction fetch and program-counter stage feeding the combinational control decoder. It holds the PC, presents the PC to the external instruction ROM, and forwards the 9-bit instruction to the decoder. It consumes the decoder's pc_jmp_en and LutPointer to redirect through a 16-entry jump-target LUT, and runs a start/done handshake with the testbench or top level.

---
 rtl/fetch_unit.sv | 105 ++++++++++
 tb/tb_fetch_unit.sv | 521 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch / PC stage with 16-entry jump-target LUT and start/done handshake.
// Optional cycle counter on output cycle_count when FETCH_CYCLE_CNT_EN is defined.
module fetch_unit #(
    parameter int          PC_W         = 10,
    parameter int          PROG_LEN     = 1024,
    parameter logic [8:0]  HALT_INSTR   = 9'h1FF,
    parameter logic [8:0]  BUBBLE_INSTR = 9'h000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            lut_wr_en,
    input  logic [3:0]      lut_wr_addr,
    input  logic [PC_W-1:0] lut_wr_data,
    input  logic [8:0]      rom_instr,
    input  logic            pc_jmp_en,
    input  logic [3:0]      LutPointer,
    output logic [PC_W-1:0] prog_ctr,
    output logic [8:0]      instr,
    output logic            running,
    output logic            done
`ifdef FETCH_CYCLE_CNT_EN
    ,
    output logic [15:0]     cycle_count
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam logic [PC_W-1:0] LAST_PC = PC_W'(PROG_LEN - 1);

    state_t          state;
    logic [PC_W-1:0] lut [16];
    logic [PC_W-1:0] jmp_tgt;
    logic            tgt_ok;

    assign jmp_tgt = lut[LutPointer];
    assign tgt_ok  = (jmp_tgt <= LAST_PC);

    assign running = (state == RUN);
    assign done    = (state == DONE);
    assign instr   = (state == RUN) ? rom_instr : BUBBLE_INSTR;

    // Halt beats jump, jump beats end-of-program, so a jump at LAST_PC is honoured.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            prog_ctr <= '0;
            for (int i = 0; i < 16; i++) begin
                lut[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (lut_wr_en) begin
                        lut[lut_wr_addr] <= lut_wr_data;
                    end
                    if (start) begin
                        state    <= RUN;
                        prog_ctr <= '0;
                    end
                end
                RUN: begin
                    if (rom_instr == HALT_INSTR) begin
                        state <= DONE;
                    end else if (pc_jmp_en) begin
                        if (tgt_ok) begin
                            prog_ctr <= jmp_tgt;
                        end else begin
                            state <= DONE;
                        end
                    end else if (prog_ctr == LAST_PC) begin
                        state <= DONE;
                    end else begin
                        prog_ctr <= prog_ctr + 1'b1;
                    end
                end
                DONE: begin
                    if (start) begin
                        state    <= RUN;
                        prog_ctr <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FETCH_CYCLE_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_count <= '0;
        end else if (state != RUN && start) begin
            cycle_count <= '0;
        end else if (state == RUN && cycle_count != 16'hFFFF) begin
            cycle_count <= cycle_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed and random programs checked against a trace predictor.
// Build with FETCH_CYCLE_CNT_EN defined to also check cycle_count.
module tb_fetch_unit;

    localparam int PL = 32;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       lut_wr_en = 1'b0;
    logic [3:0] lut_wr_addr = '0;
    logic [9:0] lut_wr_data = '0;
    logic [8:0] rom_instr;
    logic       pc_jmp_en;
    logic [3:0] LutPointer;
    logic [9:0] prog_ctr;
    logic [8:0] instr;
    logic       running;
    logic       done;
`ifdef FETCH_CYCLE_CNT_EN
    logic [15:0] cycle_count;
`endif

    fetch_unit #(.PC_W(10), .PROG_LEN(PL)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .lut_wr_en(lut_wr_en),
        .lut_wr_addr(lut_wr_addr),
        .lut_wr_data(lut_wr_data),
        .rom_instr(rom_instr),
        .pc_jmp_en(pc_jmp_en),
        .LutPointer(LutPointer),
        .prog_ctr(prog_ctr),
        .instr(instr),
        .running(running),
        .done(done)
`ifdef FETCH_CYCLE_CNT_EN
        ,
        .cycle_count(cycle_count)
`endif
    );

    always #5 clk = ~clk;

    // Program image and decoder behaviour, both indexed by the presented PC.
    logic [8:0] rom  [1024];
    bit         jen  [1024];
    logic [3:0] jptr [1024];

    assign rom_instr  = rom[prog_ctr];
    assign pc_jmp_en  = jen[prog_ctr];
    assign LutPointer = jptr[prog_ctr];

    int tests_run = 0;
    int tests_failed = 0;

    logic [9:0] m_lut [16];
    int         exp_pc[$];
    bit         exp_term;

    int         obs_pc[$];
    logic [8:0] obs_instr[$];
    logic       first_done;
    logic       end_done;
    logic       end_run;
    logic [9:0] end_pc;
    logic [8:0] end_instr;
    logic [15:0] end_cnt;

    task automatic clear_prog();
        for (int i = 0; i < 1024; i++) begin
            rom[i]  = 9'($urandom_range(1, 510));
            jen[i]  = 1'b0;
            jptr[i] = '0;
        end
    endtask

    // Address trace a run should produce, from the program rules alone.
    task automatic predict(input int maxc);
        int pc;
        pc = 0;
        exp_pc.delete();
        exp_term = 1'b0;
        while (exp_pc.size() < maxc) begin
            exp_pc.push_back(pc);
            if (rom[pc] == 9'h1FF) begin
                exp_term = 1'b1;
                break;
            end
            if (jen[pc]) begin
                if (int'(m_lut[jptr[pc]]) < PL) begin
                    pc = int'(m_lut[jptr[pc]]);
                end else begin
                    exp_term = 1'b1;
                    break;
                end
            end else if (pc == PL - 1) begin
                exp_term = 1'b1;
                break;
            end else begin
                pc = pc + 1;
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 16; i++) m_lut[i] = '0;
    endtask

    task automatic wlut(input logic [3:0] a, input logic [9:0] d);
        lut_wr_en = 1'b1;
        lut_wr_addr = a;
        lut_wr_data = d;
        @(posedge clk);
        #1;
        lut_wr_en = 1'b0;
        m_lut[a] = d;
    endtask

    // Starts a run and records what the DUT presents; wcyc -1 writes with start,
    // wcyc >= 0 pulses a LUT write plus start during that RUN cycle.
    task automatic run(input int maxc, input int wcyc,
                       input logic [3:0] wa, input logic [9:0] wd);
        int n;
        obs_pc.delete();
        obs_instr.delete();
        start = 1'b1;
        if (wcyc == -1) begin
            lut_wr_en = 1'b1;
            lut_wr_addr = wa;
            lut_wr_data = wd;
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        lut_wr_en = 1'b0;
        first_done = done;
        n = 0;
        while (running && n < maxc) begin
            obs_pc.push_back(int'(prog_ctr));
            obs_instr.push_back(instr);
            if (n == wcyc) begin
                lut_wr_en = 1'b1;
                lut_wr_addr = wa;
                lut_wr_data = wd;
                start = 1'b1;
            end
            @(posedge clk);
            #1;
            lut_wr_en = 1'b0;
            start = 1'b0;
            n++;
        end
        end_done = done;
        end_run = running;
        end_pc = prog_ctr;
        end_instr = instr;
`ifdef FETCH_CYCLE_CNT_EN
        end_cnt = cycle_count;
`else
        end_cnt = '0;
`endif
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 16; i++) m_lut[i] = '0;
        tests_run++;
        if (prog_ctr !== 10'd0 || running !== 1'b0 || done !== 1'b0 || instr !== 9'h000) begin
            tests_failed++;
            $display("FAIL reset: pc %0d run %b done %b instr %h, want 0 0 0 000",
                     prog_ctr, running, done, instr);
        end
`ifdef FETCH_CYCLE_CNT_EN
        tests_run++;
        if (cycle_count !== 16'd0) begin
            tests_failed++;
            $display("FAIL reset_cnt: got %0d want 0", cycle_count);
        end
`endif
    endtask

    task automatic test_straight();
        do_reset();
        clear_prog();
        rom[5] = 9'h1FF;
        predict(64);
        run(64, -2, 4'd0, 10'd0);
        tests_run++;
        if (obs_pc.size() != 6 || exp_pc.size() != 6) begin
            tests_failed++;
            $display("FAIL straight_len: got %0d want 6", obs_pc.size());
        end
        for (int i = 0; i < obs_pc.size() && i < exp_pc.size(); i++) begin
            tests_run++;
            if (obs_pc[i] != exp_pc[i] || obs_instr[i] !== rom[exp_pc[i]]) begin
                tests_failed++;
                $display("FAIL straight[%0d]: pc %0d instr %h want pc %0d instr %h",
                         i, obs_pc[i], obs_instr[i], exp_pc[i], rom[exp_pc[i]]);
            end
        end
        tests_run++;
        if (end_done !== 1'b1 || end_run !== 1'b0 || end_pc !== 10'd5 || end_instr !== 9'h000) begin
            tests_failed++;
            $display("FAIL straight_end: done %b run %b pc %0d instr %h want 1 0 5 000",
                     end_done, end_run, end_pc, end_instr);
        end
`ifdef FETCH_CYCLE_CNT_EN
        tests_run++;
        if (end_cnt !== 16'd6) begin
            tests_failed++;
            $display("FAIL straight_cnt: got %0d want 6", end_cnt);
        end
`endif
    endtask

    task automatic test_jump();
        do_reset();
        clear_prog();
        wlut(4'd3, 10'd20);
        jen[2] = 1'b1;
        jptr[2] = 4'd3;
        rom[22] = 9'h1FF;
        predict(64);
        run(64, -2, 4'd0, 10'd0);
        tests_run++;
        if (obs_pc.size() != exp_pc.size()) begin
            tests_failed++;
            $display("FAIL jump_len: got %0d want %0d", obs_pc.size(), exp_pc.size());
        end
        for (int i = 0; i < obs_pc.size() && i < exp_pc.size(); i++) begin
            tests_run++;
            if (obs_pc[i] != exp_pc[i]) begin
                tests_failed++;
                $display("FAIL jump[%0d]: pc %0d want %0d", i, obs_pc[i], exp_pc[i]);
            end
        end
        tests_run++;
        if (end_done !== 1'b1 || end_pc !== 10'd22) begin
            tests_failed++;
            $display("FAIL jump_end: done %b pc %0d want 1 22", end_done, end_pc);
        end
    endtask

    task automatic test_lut_write_timing();
        do_reset();
        clear_prog();
        jen[0] = 1'b1;
        jptr[0] = 4'd7;
        rom[6] = 9'h1FF;
        m_lut[7] = 10'd5;
        predict(16);
        run(16, -1, 4'd7, 10'd5);
        tests_run++;
        if (obs_pc.size() != exp_pc.size()) begin
            tests_failed++;
            $display("FAIL samecyc_len: got %0d want %0d", obs_pc.size(), exp_pc.size());
        end
        for (int i = 0; i < obs_pc.size() && i < exp_pc.size(); i++) begin
            tests_run++;
            if (obs_pc[i] != exp_pc[i]) begin
                tests_failed++;
                $display("FAIL samecyc[%0d]: pc %0d want %0d", i, obs_pc[i], exp_pc[i]);
            end
        end
        // Second run from DONE: write attempted in RUN must not reach the LUT.
        rom[6] = 9'h055;
        jen[6] = 1'b1;
        jptr[6] = 4'd7;
        predict(7);
        run(7, 1, 4'd7, 10'd9);
        tests_run++;
        if (obs_pc.size() != exp_pc.size()) begin
            tests_failed++;
            $display("FAIL runwr_len: got %0d want %0d", obs_pc.size(), exp_pc.size());
        end
        for (int i = 0; i < obs_pc.size() && i < exp_pc.size(); i++) begin
            tests_run++;
            if (obs_pc[i] != exp_pc[i]) begin
                tests_failed++;
                $display("FAIL runwr[%0d]: pc %0d want %0d", i, obs_pc[i], exp_pc[i]);
            end
        end
        tests_run++;
        if (end_run !== 1'b1) begin
            tests_failed++;
            $display("FAIL runwr_end: running %b want 1", end_run);
        end
    endtask

    task automatic test_end_of_prog();
        do_reset();
        clear_prog();
        predict(64);
        run(64, -2, 4'd0, 10'd0);
        tests_run++;
        if (obs_pc.size() != PL || exp_pc.size() != PL) begin
            tests_failed++;
            $display("FAIL eop_len: got %0d want %0d", obs_pc.size(), PL);
        end
        for (int i = 0; i < obs_pc.size() && i < exp_pc.size(); i++) begin
            tests_run++;
            if (obs_pc[i] != exp_pc[i]) begin
                tests_failed++;
                $display("FAIL eop[%0d]: pc %0d want %0d", i, obs_pc[i], exp_pc[i]);
            end
        end
        tests_run++;
        if (end_done !== 1'b1 || end_pc !== 10'(PL - 1)) begin
            tests_failed++;
            $display("FAIL eop_end: done %b pc %0d want 1 %0d", end_done, end_pc, PL - 1);
        end
        do_reset();
        wlut(4'd4, 10'd2);
        jen[PL-1] = 1'b1;
        jptr[PL-1] = 4'd4;
        predict(40);
        run(40, -2, 4'd0, 10'd0);
        tests_run++;
        if (obs_pc.size() != 40) begin
            tests_failed++;
            $display("FAIL eopjmp_len: got %0d want 40", obs_pc.size());
        end
        for (int i = 0; i < obs_pc.size() && i < exp_pc.size(); i++) begin
            tests_run++;
            if (obs_pc[i] != exp_pc[i]) begin
                tests_failed++;
                $display("FAIL eopjmp[%0d]: pc %0d want %0d", i, obs_pc[i], exp_pc[i]);
            end
        end
        tests_run++;
        if (end_run !== 1'b1 || end_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL eopjmp_end: run %b done %b want 1 0", end_run, end_done);
        end
    endtask

    task automatic test_out_of_range();
        do_reset();
        clear_prog();
        wlut(4'd2, 10'(PL - 1));
        wlut(4'd1, 10'(PL));
        jen[1] = 1'b1;
        jptr[1] = 4'd2;
        jen[PL-1] = 1'b1;
        jptr[PL-1] = 4'd1;
        predict(64);
        run(64, -2, 4'd0, 10'd0);
        tests_run++;
        if (obs_pc.size() != 3 || exp_pc.size() != 3) begin
            tests_failed++;
            $display("FAIL oor_len: got %0d want 3", obs_pc.size());
        end
        for (int i = 0; i < obs_pc.size() && i < exp_pc.size(); i++) begin
            tests_run++;
            if (obs_pc[i] != exp_pc[i]) begin
                tests_failed++;
                $display("FAIL oor[%0d]: pc %0d want %0d", i, obs_pc[i], exp_pc[i]);
            end
        end
        tests_run++;
        if (end_done !== 1'b1 || end_pc !== 10'(PL - 1)) begin
            tests_failed++;
            $display("FAIL oor_end: done %b pc %0d want 1 %0d", end_done, end_pc, PL - 1);
        end
    endtask

    task automatic test_reset_midrun();
        do_reset();
        clear_prog();
        wlut(4'd3, 10'd20);
        run(4, -2, 4'd0, 10'd0);
        tests_run++;
        if (prog_ctr !== 10'd4 || running !== 1'b1) begin
            tests_failed++;
            $display("FAIL midrun_pre: pc %0d run %b want 4 1", prog_ctr, running);
        end
        do_reset();
        tests_run++;
        if (prog_ctr !== 10'd0 || running !== 1'b0 || done !== 1'b0 || instr !== 9'h000) begin
            tests_failed++;
            $display("FAIL midrun_rst: pc %0d run %b done %b instr %h want 0 0 0 000",
                     prog_ctr, running, done, instr);
        end
        jen[1] = 1'b1;
        jptr[1] = 4'd3;
        predict(4);
        run(4, -2, 4'd0, 10'd0);
        for (int i = 0; i < obs_pc.size() && i < exp_pc.size(); i++) begin
            tests_run++;
            if (obs_pc[i] != exp_pc[i]) begin
                tests_failed++;
                $display("FAIL midrun_lut[%0d]: pc %0d want %0d", i, obs_pc[i], exp_pc[i]);
            end
        end
        tests_run++;
        if (obs_pc.size() != 4) begin
            tests_failed++;
            $display("FAIL midrun_len: got %0d want 4", obs_pc.size());
        end
    endtask

    task automatic test_restart_from_done();
        do_reset();
        clear_prog();
        rom[2] = 9'h1FF;
        run(16, -2, 4'd0, 10'd0);
        tests_run++;
        if (end_done !== 1'b1 || end_pc !== 10'd2) begin
            tests_failed++;
            $display("FAIL restart_first: done %b pc %0d want 1 2", end_done, end_pc);
        end
        rom[2] = 9'h0A5;
        rom[3] = 9'h1FF;
        predict(16);
        run(16, -2, 4'd0, 10'd0);
        tests_run++;
        if (first_done !== 1'b0 || obs_pc.size() == 0) begin
            tests_failed++;
            $display("FAIL restart_done_fall: done %b len %0d want 0 nonzero",
                     first_done, obs_pc.size());
        end else if (obs_pc[0] != 0) begin
            tests_failed++;
            $display("FAIL restart_pc0: pc %0d want 0", obs_pc[0]);
        end
        tests_run++;
        if (obs_pc.size() != exp_pc.size() || end_done !== 1'b1 || end_pc !== 10'd3) begin
            tests_failed++;
            $display("FAIL restart_end: len %0d done %b pc %0d want %0d 1 3",
                     obs_pc.size(), end_done, end_pc, exp_pc.size());
        end
`ifdef FETCH_CYCLE_CNT_EN
        tests_run++;
        if (end_cnt !== 16'd4) begin
            tests_failed++;
            $display("FAIL restart_cnt: got %0d want 4", end_cnt);
        end
`endif
    endtask

    task automatic test_random();
        int wcyc;
        logic [3:0] wa;
        logic [9:0] wd;
        int r;
        for (int it = 0; it < 25; it++) begin
            do_reset();
            clear_prog();
            for (int i = 0; i < PL; i++) begin
                r = $urandom_range(0, 15);
                if (r == 0) rom[i] = 9'h1FF;
                if (r >= 1 && r <= 3) begin
                    jen[i] = 1'b1;
                    jptr[i] = 4'($urandom_range(0, 15));
                end
            end
            for (int k = 0; k < 16; k++) wlut(4'(k), 10'($urandom_range(0, 40)));
            wcyc = int'($urandom_range(0, 10)) - 2;
            wa = 4'($urandom_range(0, 15));
            wd = 10'($urandom_range(0, 40));
            if (wcyc == -1) m_lut[wa] = wd;
            predict(48);
            run(48, wcyc, wa, wd);
            tests_run++;
            if (obs_pc.size() != exp_pc.size()) begin
                tests_failed++;
                $display("FAIL rand%0d_len: got %0d want %0d", it, obs_pc.size(), exp_pc.size());
            end
            for (int i = 0; i < obs_pc.size() && i < exp_pc.size(); i++) begin
                tests_run++;
                if (obs_pc[i] != exp_pc[i] || obs_instr[i] !== rom[exp_pc[i]]) begin
                    tests_failed++;
                    $display("FAIL rand%0d[%0d]: pc %0d instr %h want pc %0d instr %h",
                             it, i, obs_pc[i], obs_instr[i], exp_pc[i], rom[exp_pc[i]]);
                end
            end
            tests_run++;
            if (exp_term && (end_done !== 1'b1 || end_pc !== 10'(exp_pc[exp_pc.size()-1]))) begin
                tests_failed++;
                $display("FAIL rand%0d_end: done %b pc %0d want 1 %0d",
                         it, end_done, end_pc, exp_pc[exp_pc.size()-1]);
            end else if (!exp_term && end_run !== 1'b1) begin
                tests_failed++;
                $display("FAIL rand%0d_end: running %b want 1", it, end_run);
            end
`ifdef FETCH_CYCLE_CNT_EN
            if (exp_term) begin
                tests_run++;
                if (end_cnt !== 16'(exp_pc.size())) begin
                    tests_failed++;
                    $display("FAIL rand%0d_cnt: got %0d want %0d", it, end_cnt, exp_pc.size());
                end
            end
`endif
        end
    endtask

    initial begin
        clear_prog();
        test_reset();
        test_straight();
        test_jump();
        test_lut_write_timing();
        test_end_of_prog();
        test_out_of_range();
        test_reset_midrun();
        test_restart_from_done();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
